key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, setting the consecutive stable samples required to accept a level change (legal range 2..65535).
REQ-002 SHALL have parameter CNT_W, default 16, setting the per-channel stable-counter width; it SHALL hold DEBOUNCE_CYCLES-1.
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port key_in, input, 3 bits: raw asynchronous push-buttons, bit2=E, bit1=F, bit0=G; 1 = pressed.
REQ-006 SHALL have port key_level, output, 3 bits: debounced key state per channel.
REQ-007 SHALL have port key_press, output, 3 bits: one-cycle pulse per channel on each accepted press.
REQ-008 SHALL have port key_release, output, 3 bits: one-cycle pulse per channel on each accepted release.
REQ-009 SHALL have port key_code, output, 2 bits: highest-priority held key; E=3, F=2, G=1, none=0.
REQ-010 SHALL have port key_valid, output, 1 bit: high when any key_level bit is 1.

Function
REQ-011 Each key_in bit SHALL pass through a 2-flop synchronizer; the second flop output is the channel sample s.
REQ-012 Each channel SHALL run an independent 4-state FSM: IDLE, PRESS_CHK, HELD, REL_CHK, with its own counter cnt.
REQ-013 In IDLE with s=1, the FSM SHALL go to PRESS_CHK with cnt=1; with s=0 it SHALL stay in IDLE with cnt=0.
REQ-014 In PRESS_CHK with s=0, the FSM SHALL go to IDLE with cnt=0; the glitch is discarded and no pulse is produced.
REQ-015 In PRESS_CHK with s=1 and cnt=DEBOUNCE_CYCLES-1, the FSM SHALL go to HELD and register key_press=1 for exactly the next cycle; otherwise it SHALL increment cnt.
REQ-016 HELD and REL_CHK SHALL mirror IDLE and PRESS_CHK with s inverted: s=0 starts REL_CHK; s=1 returns to HELD; an accepted release goes to IDLE with a one-cycle key_release.
REQ-017 key_level SHALL be 1 exactly while the channel is in HELD or REL_CHK, registered with the state.
REQ-018 Latency: if key_in is sampled 1 at edge k and held, key_press SHALL be high in the cycle after edge k+DEBOUNCE_CYCLES+1 (default: edge k+5); release latency SHALL be identical.
REQ-019 Any input pulse sampled stable for fewer than DEBOUNCE_CYCLES consecutive s samples SHALL produce no output change.
REQ-020 Channels SHALL be fully independent: simultaneous presses or releases on several channels SHALL pulse every affected bit in the same cycle.
REQ-021 key_code and key_valid SHALL be combinational from key_level, with fixed priority E>F>G.
REQ-022 cnt SHALL saturate and never wrap; it is only compared to DEBOUNCE_CYCLES-1.

Reset
REQ-023 While sys_rst=1 at an edge, the synchronizers, all states (to IDLE), all cnt values and all registered outputs SHALL clear to 0; key_code=0 and key_valid=0.
REQ-024 Reset mid-debounce SHALL discard progress, emit no pulse, and not generate a release for a key that was HELD.
REQ-025 A key held through reset deassertion SHALL be reported as a fresh press, following the REQ-018 latency measured from the first post-reset sample.

Verification
REQ-026 Clean press: key_in=3'b001 for 10 cycles, then 0 -> key_press=3'b001 for 1 cycle at edge k+5; key_level[0] high; key_code=1; key_release[0] pulses 5 edges after the release sample.
REQ-027 Bounce: per-cycle pattern 3'b001, 3'b100, 3'b000 repeated 5 times -> key_press, key_release and key_level stay 0 throughout.
REQ-028 Simultaneous: key_in=3'b101 held 10 cycles -> key_press=3'b101 in one cycle, key_code=3; then release E only -> key_code=1.
REQ-029 Release bounce: while HELD, drop key_in for 2 cycles, then restore -> no key_release; key_level stays 1.
REQ-030 Reset mid-PRESS_CHK: assert sys_rst for 1 cycle after 2 stable samples, key still held -> no pulse during reset; key_press arrives 5 edges after the first post-reset sample.

Source files
------------

// File: rtl/key_debounce.sv
// Three-channel push-button debouncer: 2-flop synchronizer, per-channel press/release
// qualification FSM, registered level and edge pulses, and a priority key code.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [2:0] key_in,
    output logic [2:0] key_level,
    output logic [2:0] key_press,
    output logic [2:0] key_release,
    output logic [1:0] key_code,
    output logic       key_valid
);

    localparam int unsigned N_KEYS = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    logic [N_KEYS-1:0] sync_q1;
    logic [N_KEYS-1:0] sync_q2;
    state_t            state_q [N_KEYS];
    state_t            state_d [N_KEYS];
    logic [CNT_W-1:0]  cnt_q   [N_KEYS];
    logic [CNT_W-1:0]  cnt_d   [N_KEYS];
    logic [N_KEYS-1:0] press_d;
    logic [N_KEYS-1:0] release_d;
    logic [N_KEYS-1:0] level_d;

    // Synchronizers, per-channel state/counter and registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q1     <= '0;
            sync_q2     <= '0;
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync_q1     <= key_in;
            sync_q2     <= sync_q1;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next state: a candidate level must be seen DEBOUNCE_CYCLES samples in a row
    always_comb begin
        press_d   = '0;
        release_d = '0;
        level_d   = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (sync_q2[i]) begin
                        state_d[i] = PRESS_CHK;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                PRESS_CHK: begin
                    if (!sync_q2[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                        press_d[i] = 1'b1;
                    end else if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!sync_q2[i]) begin
                        state_d[i] = REL_CHK;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                REL_CHK: begin
                    if (sync_q2[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = IDLE;
                        cnt_d[i]     = '0;
                        release_d[i] = 1'b1;
                    end else if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            level_d[i] = (state_d[i] == HELD) || (state_d[i] == REL_CHK);
        end
    end

    // Fixed priority E > F > G
    always_comb begin
        key_code = 2'd0;
        if (key_level[2]) begin
            key_code = 2'd3;
        end else if (key_level[1]) begin
            key_code = 2'd2;
        end else if (key_level[0]) begin
            key_code = 2'd1;
        end
    end

    assign key_valid = |key_level;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed vector table, corner-case sequences and random
// stimulus, all checked against a run-length reference model of the debouncer.
module tb_key_debounce;

    localparam int unsigned DEB = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [2:0] key_in  = 3'b000;
    logic [2:0] key_level;
    logic [2:0] key_press;
    logic [2:0] key_release;
    logic [1:0] key_code;
    logic       key_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: raw-input delay line plus a run length of samples disagreeing with the level
    logic [2:0] m_h1 = '0;
    logic [2:0] m_h2 = '0;
    logic [2:0] m_lvl = '0;
    logic [2:0] m_prs = '0;
    logic [2:0] m_rel = '0;
    int         m_run [3] = '{0, 0, 0};

    key_debounce #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_code   (key_code),
        .key_valid  (key_valid)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [1:0] prio_code(input logic [2:0] lvl);
        if (lvl[2]) return 2'd3;
        if (lvl[1]) return 2'd2;
        if (lvl[0]) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input logic [2:0] k, input logic r);
        logic [2:0] s;
        m_prs = '0;
        m_rel = '0;
        if (r) begin
            m_h1 = '0;
            m_h2 = '0;
            m_lvl = '0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
        end else begin
            s = m_h2;
            for (int i = 0; i < 3; i++) begin
                if (s[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == int'(DEB)) begin
                        m_lvl[i] = s[i];
                        m_run[i] = 0;
                        if (s[i]) m_prs[i] = 1'b1;
                        else      m_rel[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_h2 = m_h1;
            m_h1 = k;
        end
    endtask

    // One clock: drive, advance model at the edge, compare all outputs 1 time unit later
    task automatic step(input logic [2:0] k, input logic r);
        key_in  = k;
        sys_rst = r;
        @(posedge sys_clk);
        model_edge(k, r);
        #1;
        cyc++;
        chk("model", {4'h0, key_level, key_press, key_release, key_code, key_valid},
            {4'h0, m_lvl, m_prs, m_rel, prio_code(m_lvl), |m_lvl});
    endtask

    typedef struct {
        logic [2:0] key;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
        logic [1:0] code;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [2:0] acc;
        logic [2:0] lvl_and;
        int         hits;
        int         first;
        int         hold;
        logic [2:0] rk;

        // Clean press of G: sampled at row 0, held 10 rows, released at row 10
        for (int i = 0; i < 17; i++) begin
            tbl[i].key  = (i < 10) ? 3'b001 : 3'b000;
            tbl[i].lvl  = (i >= 5 && i <= 14) ? 3'b001 : 3'b000;
            tbl[i].prs  = (i == 5) ? 3'b001 : 3'b000;
            tbl[i].rel  = (i == 15) ? 3'b001 : 3'b000;
            tbl[i].code = (i >= 5 && i <= 14) ? 2'd1 : 2'd0;
        end

        for (int i = 0; i < 3; i++) step(3'b111, 1'b1);
        chk("reset_state", {5'h0, key_level, key_press, key_release, key_code, key_valid}, 16'h0);
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].key, 1'b0);
            chk("tbl_level", 16'(key_level), 16'(tbl[i].lvl));
            chk("tbl_press", 16'(key_press), 16'(tbl[i].prs));
            chk("tbl_release", 16'(key_release), 16'(tbl[i].rel));
            chk("tbl_code", 16'(key_code), 16'(tbl[i].code));
        end

        // Bounce across G and E never qualifies
        acc = '0;
        for (int r = 0; r < 5; r++) begin
            step(3'b001, 1'b0); acc |= key_press | key_release | key_level;
            step(3'b100, 1'b0); acc |= key_press | key_release | key_level;
            step(3'b000, 1'b0); acc |= key_press | key_release | key_level;
        end
        for (int i = 0; i < 6; i++) begin
            step(3'b000, 1'b0); acc |= key_press | key_release | key_level;
        end
        chk("bounce_quiet", 16'(acc), 16'h0);

        // Simultaneous E+G press, then release E only
        hits = 0;
        acc  = '0;
        for (int i = 0; i < 10; i++) begin
            step(3'b101, 1'b0);
            if (key_press == 3'b101) hits++;
            else acc |= key_press;
        end
        chk("simul_press_once", 16'(hits), 16'd1);
        chk("simul_press_split", 16'(acc), 16'h0);
        chk("simul_code_e", 16'(key_code), 16'd3);
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            step(3'b001, 1'b0);
            if (key_release == 3'b100) hits++;
        end
        chk("release_e_once", 16'(hits), 16'd1);
        chk("code_after_e_rel", 16'(key_code), 16'd1);
        chk("valid_after_e_rel", 16'(key_valid), 16'd1);

        // Release bounce on held G: two low samples must not release
        acc     = '0;
        lvl_and = 3'b111;
        for (int i = 0; i < 2; i++) begin
            step(3'b000, 1'b0); acc |= key_release; lvl_and &= key_level;
        end
        for (int i = 0; i < 8; i++) begin
            step(3'b001, 1'b0); acc |= key_release; lvl_and &= key_level;
        end
        chk("rel_bounce_norel", 16'(acc), 16'h0);
        chk("rel_bounce_level", 16'(lvl_and[0]), 16'd1);
        for (int i = 0; i < 8; i++) step(3'b000, 1'b0);
        chk("idle_again", 16'(key_level), 16'h0);

        // Reset mid PRESS_CHK with the key still held
        for (int i = 0; i < 4; i++) step(3'b001, 1'b0);
        step(3'b001, 1'b1);
        chk("rst_no_pulse", 16'({key_press, key_release, key_level}), 16'h0);
        first = -1;
        for (int i = 0; i < 10; i++) begin
            step(3'b001, 1'b0);
            if (key_press[0] && first < 0) first = i;
        end
        chk("rst_fresh_press_at", 16'(first), 16'd5);

        // Reset while held: no release pulse afterwards
        acc = '0;
        step(3'b000, 1'b1);
        acc |= key_release;
        for (int i = 0; i < 8; i++) begin
            step(3'b000, 1'b0); acc |= key_release;
        end
        chk("rst_held_norel", 16'(acc), 16'h0);

        // Random hold lengths straddling the qualification length, occasional reset
        for (int n = 0; n < 400; n++) begin
            rk   = 3'($urandom_range(0, 7));
            hold = int'($urandom_range(1, 8));
            for (int j = 0; j < hold; j++) begin
                step(rk, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
